dcache_controller: RTL and testbench

- Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the 16-bit SRAM controller.
- Serves MEM-stage loads and stores. Read hits complete in the request cycle.
- Read misses fetch one 64-bit line through the SRAM controller's 64-bit read port. Stores always go through to SRAM.
- Drives `ready`, which the pipeline uses as its freeze signal (freeze = !ready).

---
 rtl/dcache_controller.sv | 148 ++++++++++++++
 tb/tb_dcache_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage
// and a 64-bit-line SRAM controller. A read hit completes in the request cycle; everything else stalls.
module dcache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_READ_MISS, S_WRITE} state_t;

    state_t             r_state, w_next;
    logic [31:0]        r_addr, r_wdata;
    logic [SETS-1:0]    r_valid0, r_valid1, r_lru;
    logic [TAG_W-1:0]   r_tag0  [SETS];
    logic [TAG_W-1:0]   r_tag1  [SETS];
    logic [63:0]        r_data0 [SETS];
    logic [63:0]        r_data1 [SETS];

    logic [31:0]        w_addr;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit0, w_hit1, w_hit, w_victim;
    logic [63:0]        w_hit_line;
    logic [31:0]        w_hit_word, w_fill_word;
    logic               w_unused;

    // In IDLE the lookup runs on the live request; afterwards only the latched copy is trusted.
    assign w_addr      = (r_state == S_IDLE) ? mem_address : r_addr;
    assign w_idx       = w_addr[INDEX_W+2:3];
    assign w_tag       = w_addr[INDEX_W+TAG_W+2:INDEX_W+3];
    assign w_unused    = ^{w_addr[31:INDEX_W+TAG_W+3], w_addr[1:0]};
    assign w_hit0      = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1      = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit       = w_hit0 || w_hit1;
    assign w_hit_line  = w_hit0 ? r_data0[w_idx] : r_data1[w_idx];
    assign w_hit_word  = w_addr[2] ? w_hit_line[63:32] : w_hit_line[31:0];
    assign w_fill_word = w_addr[2] ? sram_rdata[63:32] : sram_rdata[31:0];
    assign w_victim    = !r_valid0[w_idx] ? 1'b0 : (!r_valid1[w_idx] ? 1'b1 : r_lru[w_idx]);

    assign sram_address = r_addr;
    assign sram_wdata   = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        ready      = 1'b1;
        mem_rdata  = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_wr_en) begin
                    ready  = 1'b0;
                    w_next = S_WRITE;
                end else if (mem_rd_en) begin
                    if (w_hit) begin
                        mem_rdata = w_hit_word;
                    end else begin
                        ready  = 1'b0;
                        w_next = S_READ_MISS;
                    end
                end
            end
            S_READ_MISS: begin
                sram_rd_en = 1'b1;
                if (sram_ready) begin
                    mem_rdata = w_fill_word;
                    w_next    = S_IDLE;
                end else begin
                    ready = 1'b0;
                end
            end
            S_WRITE: begin
                sram_wr_en = 1'b1;
                if (sram_ready) w_next = S_IDLE;
                else            ready  = 1'b0;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Tag/data arrays are never reset; the valid bits alone gate them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_wr_en || mem_rd_en) begin
                        r_addr  <= mem_address;
                        r_wdata <= mem_wdata;
                    end
                    if (!mem_wr_en && mem_rd_en && w_hit) r_lru[w_idx] <= w_hit0;
                end
                S_READ_MISS: begin
                    if (sram_ready) begin
                        if (w_victim) begin
                            r_valid1[w_idx] <= 1'b1;
                            r_tag1[w_idx]   <= w_tag;
                            r_data1[w_idx]  <= sram_rdata;
                        end else begin
                            r_valid0[w_idx] <= 1'b1;
                            r_tag0[w_idx]   <= w_tag;
                            r_data0[w_idx]  <= sram_rdata;
                        end
                        r_lru[w_idx] <= ~w_victim;
                    end
                end
                S_WRITE: begin
                    if (sram_ready && w_hit) begin
                        if (w_hit0) begin
                            if (r_addr[2]) r_data0[w_idx][63:32] <= r_wdata;
                            else           r_data0[w_idx][31:0]  <= r_wdata;
                        end else begin
                            if (r_addr[2]) r_data1[w_idx][63:32] <= r_wdata;
                            else           r_data1[w_idx][31:0]  <= r_wdata;
                        end
                        r_lru[w_idx] <= w_hit0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random traffic against a
// recency-ordered per-set line list model; the bench plays the SRAM controller.
module tb_dcache_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        ready, sram_rd_en, sram_wr_en, sram_ready;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;

    int total = 0;
    int bad   = 0;

    dcache_controller dut (
        .clk(clk), .rst(rst),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ready(ready),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: per set, up to two resident lines, slot 0 most recently used.
    logic [9:0]  m_tag  [64][2];
    logic [63:0] m_data [64][2];
    int          m_cnt  [64];

    function automatic int m_find(input int s, input logic [9:0] t);
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == t) return i;
        return -1;
    endfunction

    function automatic void m_touch(input int s, input int p);
        logic [9:0]  t;
        logic [63:0] d;
        if (p == 1) begin
            t = m_tag[s][0];  d = m_data[s][0];
            m_tag[s][0] = m_tag[s][1];  m_data[s][0] = m_data[s][1];
            m_tag[s][1] = t;  m_data[s][1] = d;
        end
    endfunction

    function automatic void m_insert(input int s, input logic [9:0] t, input logic [63:0] d);
        m_tag[s][1]  = m_tag[s][0];
        m_data[s][1] = m_data[s][0];
        m_tag[s][0]  = t;
        m_data[s][0] = d;
        if (m_cnt[s] < 2) m_cnt[s]++;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    endfunction

    function automatic logic [31:0] wsel(input logic [63:0] l, input logic b);
        return b ? l[63:32] : l[31:0];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0; sram_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_rdata", 64'(mem_rdata), 64'(0));
        chk("rst_srd", 64'(sram_rd_en), 64'(0));
        chk("rst_swr", 64'(sram_wr_en), 64'(0));
    endtask

    task automatic do_read(input logic [31:0] a, input int lat, input logic [63:0] line);
        int s, p;
        logic [9:0] t;
        s = int'(a[8:3]); t = a[18:9]; p = m_find(s, t);
        @(posedge clk); #1;
        mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_address = a;
        @(negedge clk);
        chk("rd_hit", 64'(ready), 64'(p >= 0));
        if (p >= 0) begin
            chk("rd_data", 64'(mem_rdata), 64'(wsel(m_data[s][p], a[2])));
            chk("rd_nosram", 64'(sram_rd_en), 64'(0));
            m_touch(s, p);
            @(posedge clk); #1;
            mem_rd_en = 1'b0;
        end else begin
            for (int k = 0; k < lat; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("miss_srd", 64'(sram_rd_en), 64'(1));
                chk("miss_swr", 64'(sram_wr_en), 64'(0));
                chk("miss_addr", 64'(sram_address), 64'(a));
                chk("miss_stall", 64'(ready), 64'(0));
            end
            @(posedge clk); #1;
            sram_ready = 1'b1; sram_rdata = line;
            @(negedge clk);
            chk("fill_ready", 64'(ready), 64'(1));
            chk("fill_data", 64'(mem_rdata), 64'(wsel(line, a[2])));
            @(posedge clk); #1;
            sram_ready = 1'b0; mem_rd_en = 1'b0;
            m_insert(s, t, line);
            @(negedge clk);
            chk("srd_drop", 64'(sram_rd_en), 64'(0));
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both, input int lat);
        int s, p;
        s = int'(a[8:3]); p = m_find(s, a[18:9]);
        @(posedge clk); #1;
        mem_wr_en = 1'b1; mem_rd_en = both; mem_address = a; mem_wdata = d;
        @(negedge clk);
        chk("wr_stall", 64'(ready), 64'(0));
        for (int k = 0; k < lat; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("wr_swr", 64'(sram_wr_en), 64'(1));
            chk("wr_srd", 64'(sram_rd_en), 64'(0));
            chk("wr_addr", 64'(sram_address), 64'(a));
            chk("wr_wdata", 64'(sram_wdata), 64'(d));
            chk("wr_wait", 64'(ready), 64'(0));
        end
        @(posedge clk); #1;
        sram_ready = 1'b1; sram_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("wr_done", 64'(ready), 64'(1));
        chk("wr_done_srd", 64'(sram_rd_en), 64'(0));
        @(posedge clk); #1;
        sram_ready = 1'b0; mem_wr_en = 1'b0; mem_rd_en = 1'b0;
        if (p >= 0) begin
            if (a[2]) m_data[s][p][63:32] = d;
            else      m_data[s][p][31:0]  = d;
            m_touch(s, p);
        end
        @(negedge clk);
        chk("swr_drop", 64'(sram_wr_en), 64'(0));
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3)
          | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        int op;
        rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_address = '0; mem_wdata = '0;
        sram_ready = 1'b0; sram_rdata = '0;
        m_clear();
        do_reset();

        // cold miss then same-line hit
        do_read(32'h400, 5, 64'h1111_1111_2222_2222);
        do_read(32'h404, 1, 64'h0);
        // LRU: 0x800 must evict 0x600, keeping 0x400
        do_read(32'h600, 3, {$urandom, $urandom});
        do_read(32'h400, 1, 64'h0);
        do_read(32'h800, 2, {$urandom, $urandom});
        do_read(32'h400, 1, 64'h0);
        do_read(32'h600, 2, {$urandom, $urandom});
        // write hit, then read back
        do_write(32'h404, 32'hDEAD_BEEF, 1'b0, 3);
        do_read(32'h404, 1, 64'h0);
        // write miss does not allocate
        do_write(32'h1000, 32'h55, 1'b0, 2);
        do_read(32'h1000, 2, {$urandom, $urandom});
        // simultaneous request behaves as a write
        do_write(32'h408, 32'h1234_5678, 1'b1, 2);
        do_read(32'h408, 1, {$urandom, $urandom});

        // reset two cycles into a read miss discards the fill
        do_reset();
        @(posedge clk); #1;
        mem_rd_en = 1'b1; mem_address = 32'h400;
        @(negedge clk);
        chk("rm_stall", 64'(ready), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
        @(negedge clk);
        chk("rm_srd", 64'(sram_rd_en), 64'(0));
        chk("rm_ready", 64'(ready), 64'(1));
        do_read(32'h400, 2, {$urandom, $urandom});

        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 49));
            if (op == 0)       do_reset();
            else if (op < 30)  do_read(rnd_addr(), int'($urandom_range(0, 5)), {$urandom, $urandom});
            else if (op < 45)  do_write(rnd_addr(), $urandom, 1'b0, int'($urandom_range(0, 5)));
            else               do_write(rnd_addr(), $urandom, 1'b1, int'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
